pc_stack: RTL and testbench

Parametrised program counter with a hardware return-address stack. It is the next generation of the memory-family storage elements (1-bit load register → N-bit register → counter). It adds load, increment, call and return modes, plus stack overflow and underflow detection. It sits in the CPU fetch path, and its out drives the instruction-memory address.

---
 rtl/pc_stack_pkg.sv | 19 +
 rtl/pc_stack_if.sv | 33 +++
 rtl/pc_stack_lifo_stack.sv | 57 +++++
 rtl/pc_stack.sv | 116 +++++++++++
 tb/tb_pc_stack.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pc_stack_pkg.sv
// Shared definitions for the program-counter / return-stack slice:
// control-priority opcodes and the stack-pointer width helper.
package pc_stack_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_LOAD = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_CLR  = 3'd5
  } op_e;

  // sp counts 0..depth inclusive, so it needs one more code than depth
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Control/status bundle between the fetch controller and pc_stack.
interface pc_stack_if
  import pc_stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int SPW = sp_width(DEPTH);

  logic             clr;
  logic             load;
  logic             inc;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic [SPW-1:0]   sp;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output clr, load, inc, call, ret, in,
    input  out, sp, full, empty, overflow, underflow
  );

  modport slave (
    input  clr, load, inc, call, ret, in,
    output out, sp, full, empty, overflow, underflow
  );

endinterface

// File: rtl/pc_stack_lifo_stack.sv
// Return-address LIFO: storage array plus entry counter; push when full
// and pop when empty are silently ignored.
module lifo_stack
  import pc_stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int SPW = sp_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [SPW-1:0]   sp,
  output logic             full,
  output logic             empty
);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [SPW-1:0]   sp_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (sp_r == SPW'(DEPTH));
  assign empty     = (sp_r == SPW'(0));
  assign do_push_s = push && !full && !clr;
  assign do_pop_s  = pop && !empty && !clr && !push;
  assign sp        = sp_r;
  assign top       = empty ? {WIDTH{1'b0}} : mem_r[IDXW'(sp_r - SPW'(1))];

  // entry counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r <= SPW'(0);
    end else if (clr) begin
      sp_r <= SPW'(0);
    end else if (do_push_s) begin
      sp_r <= sp_r + SPW'(1);
    end else if (do_pop_s) begin
      sp_r <= sp_r - SPW'(1);
    end else begin
      sp_r <= sp_r;
    end
  end

  // storage array; contents are don't-care after reset so it carries none
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[IDXW'(sp_r)] <= din;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with return-address stack: priority decode of
// clr > ret > call > load > inc > hold, the out register and sticky faults.
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               DEPTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}}
) (
  input logic       clk,
  input logic       rst_n,
  pc_stack_if.slave bus
);
  localparam int SPW = sp_width(DEPTH);

  op_e              op_s;
  logic [WIDTH-1:0] out_r, out_nxt_s, top_s;
  logic             ovf_r, ovf_nxt_s, unf_r, unf_nxt_s;
  logic             push_s, pop_s, clr_s;
  logic [SPW-1:0]   sp_s;
  logic             full_s, empty_s;

  // priority decode: only the highest asserted control acts
  always_comb begin
    op_s = OP_HOLD;
    if (bus.clr) begin
      op_s = OP_CLR;
    end else if (bus.ret) begin
      op_s = OP_RET;
    end else if (bus.call) begin
      op_s = OP_CALL;
    end else if (bus.load) begin
      op_s = OP_LOAD;
    end else if (bus.inc) begin
      op_s = OP_INC;
    end else begin
      op_s = OP_HOLD;
    end
  end

  // next-state for out, flags and stack controls
  always_comb begin
    out_nxt_s = out_r;
    ovf_nxt_s = ovf_r;
    unf_nxt_s = unf_r;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    clr_s     = 1'b0;
    case (op_s)
      OP_CLR: begin
        out_nxt_s = RESET_VECTOR;
        ovf_nxt_s = 1'b0;
        unf_nxt_s = 1'b0;
        clr_s     = 1'b1;
      end
      OP_RET: begin
        if (!empty_s) begin
          out_nxt_s = top_s;
          pop_s     = 1'b1;
        end else begin
          unf_nxt_s = 1'b1;
        end
      end
      OP_CALL: begin
        // the jump happens even when the push has to be dropped
        out_nxt_s = bus.in;
        if (!full_s) begin
          push_s = 1'b1;
        end else begin
          ovf_nxt_s = 1'b1;
        end
      end
      OP_LOAD: out_nxt_s = bus.in;
      OP_INC:  out_nxt_s = out_r + WIDTH'(1);
      OP_HOLD: out_nxt_s = out_r;
      default: out_nxt_s = out_r;
    endcase
  end

  // out register and sticky fault flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r <= RESET_VECTOR;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      out_r <= out_nxt_s;
      ovf_r <= ovf_nxt_s;
      unf_r <= unf_nxt_s;
    end
  end

  lifo_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (out_r + WIDTH'(1)),
    .top   (top_s),
    .sp    (sp_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign bus.out       = out_r;
  assign bus.sp        = sp_s;
  assign bus.full      = full_s;
  assign bus.empty     = empty_s;
  assign bus.overflow  = ovf_r;
  assign bus.underflow = unf_r;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed plan plus random controls,
// compared every cycle against a queue-based reference model.
module tb_pc_stack;
  localparam int          W  = 16;
  localparam int          D  = 8;
  localparam logic [15:0] RV = 16'h0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

  pc_stack #(.WIDTH(W), .DEPTH(D), .RESET_VECTOR(RV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] m_out;
  logic [15:0] m_stk [$];
  logic        m_ovf, m_unf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = RV;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // architectural rules applied to whatever the bench is driving
  task automatic model_edge();
    if (bus.clr) begin
      model_reset();
    end else if (bus.ret) begin
      if (m_stk.size() > 0) m_out = m_stk.pop_back();
      else m_unf = 1'b1;
    end else if (bus.call) begin
      if (m_stk.size() < D) m_stk.push_back(m_out + 16'd1);
      else m_ovf = 1'b1;
      m_out = bus.in;
    end else if (bus.load) begin
      m_out = bus.in;
    end else if (bus.inc) begin
      m_out = m_out + 16'd1;
    end
  endtask

  task automatic check_model();
    chk("out",       32'(bus.out),       32'(m_out));
    chk("sp",        32'(bus.sp),        32'(m_stk.size()));
    chk("full",      32'(bus.full),      32'(m_stk.size() == D));
    chk("empty",     32'(bus.empty),     32'(m_stk.size() == 0));
    chk("overflow",  32'(bus.overflow),  32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
  endtask

  task automatic step(input logic c, input logic r, input logic ca,
                      input logic l, input logic i, input logic [15:0] din);
    bus.clr  = c;
    bus.ret  = r;
    bus.call = ca;
    bus.load = l;
    bus.inc  = i;
    bus.in   = din;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    chk("midrst_out", 32'(bus.out), 32'h0000);
    #1 rst_n = 1'b1;
  endtask

  logic [15:0] t [8];
  logic [15:0] hold_out;

  initial begin
    rst_n    = 1'b0;
    bus.clr  = 1'b0;
    bus.ret  = 1'b0;
    bus.call = 1'b0;
    bus.load = 1'b0;
    bus.inc  = 1'b0;
    bus.in   = 16'h0000;
    model_reset();
    #12 rst_n = 1'b1;
    check_model();
    chk("rst_out", 32'(bus.out), 32'h0000);
    chk("rst_sp",  32'(bus.sp),  32'h0);

    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      chk("inc_out", 32'(bus.out), 32'(k));
    end
    mid_reset();

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFE);
    chk("load_fffe", 32'(bus.out), 32'h0000FFFE);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    chk("inc_ffff", 32'(bus.out), 32'h0000FFFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    chk("wrap_0", 32'(bus.out), 32'h0000);
    chk("wrap_noflag", 32'({bus.overflow, bus.underflow}), 32'h0);

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0005);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0100);
    chk("call1_out", 32'(bus.out), 32'h0100);
    chk("call1_sp",  32'(bus.sp),  32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0200);
    chk("call2_out", 32'(bus.out), 32'h0200);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("ret1_out", 32'(bus.out), 32'h0101);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("ret2_out", 32'(bus.out), 32'h0006);
    chk("ret2_empty", 32'(bus.empty), 32'h1);

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0300);
    for (int k = 0; k < 8; k++) begin
      t[k] = 16'($urandom);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, t[k]);
    end
    chk("ovf_full", 32'(bus.full), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0AAA);
    chk("ovf_out",  32'(bus.out),      32'h0AAA);
    chk("ovf_sp",   32'(bus.sp),       32'h8);
    chk("ovf_flag", 32'(bus.overflow), 32'h1);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      chk("ovf_ret", 32'(bus.out), (k < 7) ? 32'(t[6-k] + 16'd1) : 32'h0301);
    end
    chk("ovf_sticky", 32'(bus.overflow), 32'h1);

    hold_out = bus.out;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("unf_out",  32'(bus.out),       32'(hold_out));
    chk("unf_flag", 32'(bus.underflow), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0400);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0555);
    chk("prio_out", 32'(bus.out), 32'h0302);
    chk("prio_sp",  32'(bus.sp),  32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0777);
    chk("clr_out",   32'(bus.out), 32'h0000);
    chk("clr_flags", 32'({bus.overflow, bus.underflow}), 32'h0);

    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 22),
           ($urandom_range(0, 99) < 28),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 50),
           16'($urandom));
      if ($urandom_range(0, 199) == 0) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
